// File: rtl/md_pkg.sv
// md_pkg: shared op codes, select encodings and helpers for the execute stage and its MDU
package md_pkg;
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10,
    MD_MSUB  = 4'd11
  } md_op_e;
  typedef enum logic [1:0] {FWD_RD1, FWD_ALU_M, FWD_RES_W, FWD_PC8_M} fwd_sel_e;
  typedef enum logic [1:0] {A3_RT, A3_RD, A3_RA, A3_ZERO} a3_sel_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU} alu_op_e;
  localparam int LINK_REG = 31;
  // ops that launch a multi-cycle MDU operation when the unit is idle
  function automatic logic md_start_op(input logic [3:0] op);
`ifdef MDU_ACCUM_EN
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MADDU, MD_MSUB};
`else
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
`endif
  endfunction
endpackage

// File: rtl/alu.sv
// alu: existing execute-stage ALU
module alu
  import md_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        alu_ctr,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);
  // one result per operation code
  always_comb begin
    case (alu_ctr)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_NOR: y = ~(a | b);
      ALU_SLT: y = DATA_W'($signed(a) < $signed(b));
      default: y = DATA_W'(a < b);
    endcase
  end
endmodule

// File: rtl/mdu_core.sv
// mdu_core: multi-cycle multiply/divide with HI/LO; MDU_ACCUM_EN adds madd/maddu/msub
module mdu_core
  import md_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int MAX_LAT = MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT;
  localparam int CNT_W = $clog2(MAX_LAT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
  logic [DATA_W-1:0] a_mag, b_mag, q_u, r_u, q, r;
  logic [2*DATA_W-1:0] prod, acc, res;
  logic start, is_div, sgn;
  assign busy = cnt_q != '0;
  assign hi = hi_q;
  assign lo = lo_q;
  assign start = !busy && md_start_op(op);
  assign is_div = op == MD_DIV || op == MD_DIVU;
`ifdef MDU_ACCUM_EN
  assign sgn = op == MD_MULT || op == MD_DIV || op == MD_MADD || op == MD_MSUB;
`else
  assign sgn = op == MD_MULT || op == MD_DIV;
`endif
  // sign-extending to 2*DATA_W makes the truncated product correct for both signednesses
  assign prod = {{DATA_W{sgn & a[DATA_W-1]}}, a} * {{DATA_W{sgn & b[DATA_W-1]}}, b};
`ifdef MDU_ACCUM_EN
  assign acc = op == MD_MSUB ? {hi_q, lo_q} - prod :
               (op == MD_MADD || op == MD_MADDU) ? {hi_q, lo_q} + prod : prod;
`else
  assign acc = prod;
`endif
  // signed divide on magnitudes; most-negative / -1 falls out as most-negative with zero remainder
  assign a_mag = sgn && a[DATA_W-1] ? -a : a;
  assign b_mag = sgn && b[DATA_W-1] ? -b : b;
  assign q_u = a_mag / b_mag;
  assign r_u = a_mag % b_mag;
  assign q = sgn && (a[DATA_W-1] ^ b[DATA_W-1]) ? -q_u : q_u;
  assign r = sgn && a[DATA_W-1] ? -r_u : r_u;
  assign res = !is_div ? acc : b == '0 ? {a, {DATA_W{1'b1}}} : {r, q};
  // launch captures the full result; the countdown commits it to HI/LO when it reaches zero
  always_comb begin
    cnt_d = cnt_q;
    phi_d = phi_q;
    plo_d = plo_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (start) begin
      cnt_d = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      {phi_d, plo_d} = res;
    end else if (busy) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) {hi_d, lo_d} = {phi_q, plo_q};
    end else if (op == MD_MTHI) hi_d = a;
    else if (op == MD_MTLO) lo_d = a;
  end
  // state registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      phi_q <= '0;
      plo_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      phi_q <= phi_d;
      plo_q <= plo_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
endmodule

// File: rtl/execute_md_stage.sv
// execute_md_stage: E-stage forwarding, ALU, A3 select and MDU with D-stall; MDU_ACCUM_EN enables accumulate ops
module execute_md_stage
  import md_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        rs_sel,
  input  logic [1:0]        rt_sel,
  input  logic              srcb_sel,
  input  logic [2:0]        alu_ctr,
  input  logic [1:0]        a3_sel,
  input  logic [REG_W-1:0]  rd_E,
  input  logic [REG_W-1:0]  rt_E,
  input  logic [DATA_W-1:0] RD1_E,
  input  logic [DATA_W-1:0] RD2_E,
  input  logic [DATA_W-1:0] E32_E,
  input  logic [DATA_W-1:0] ALU_OUT_M,
  input  logic [DATA_W-1:0] RESULT_W,
  input  logic [DATA_W-1:0] PC8_M,
  input  logic [3:0]        md_op,
  input  logic              md_req_D,
  output logic [REG_W-1:0]  WRITE_REG_E,
  output logic [DATA_W-1:0] ALU_OUT_E,
  output logic [DATA_W-1:0] WRITE_DATA_E,
  output logic              md_busy,
  output logic              md_stall
);
  logic [DATA_W-1:0] src_a, fwd_rt, src_b, alu_y, hi, lo;
  assign src_a = rs_sel == FWD_RD1 ? RD1_E : rs_sel == FWD_ALU_M ? ALU_OUT_M :
                 rs_sel == FWD_RES_W ? RESULT_W : PC8_M;
  assign fwd_rt = rt_sel == FWD_RD1 ? RD2_E : rt_sel == FWD_ALU_M ? ALU_OUT_M :
                  rt_sel == FWD_RES_W ? RESULT_W : PC8_M;
  assign src_b = srcb_sel ? E32_E : fwd_rt;
  assign WRITE_DATA_E = fwd_rt;
  assign WRITE_REG_E = a3_sel == A3_RT ? rt_E : a3_sel == A3_RD ? rd_E :
                       a3_sel == A3_RA ? REG_W'(LINK_REG) : '0;
  assign ALU_OUT_E = md_op == MD_MFHI ? hi : md_op == MD_MFLO ? lo : alu_y;
  assign md_stall = md_req_D & (md_busy | md_start_op(md_op));
  alu #(.DATA_W(DATA_W)) u_alu (
    .alu_ctr(alu_ctr),
    .a      (src_a),
    .b      (src_b),
    .y      (alu_y)
  );
  mdu_core #(.DATA_W(DATA_W), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) u_mdu (
    .clk    (clk),
    .reset_n(reset_n),
    .op     (md_op),
    .a      (src_a),
    .b      (fwd_rt),
    .busy   (md_busy),
    .hi     (hi),
    .lo     (lo)
  );
endmodule

// File: tb/tb_execute_md_stage.sv
// tb_execute_md_stage: vector table, random datapath and MDU checks against a behavioural model
module tb_execute_md_stage;
  localparam int ML = 5, DL = 10;
  logic clk = 0, reset_n = 0;
  logic [1:0] rs_sel = 0, rt_sel = 0, a3_sel = 0;
  logic srcb_sel = 0, md_req_D = 0;
  logic [2:0] alu_ctr = 0;
  logic [4:0] rd_E = 0, rt_E = 0, WRITE_REG_E;
  logic [31:0] RD1_E = 0, RD2_E = 0, E32_E = 0, ALU_OUT_M = 0, RESULT_W = 0, PC8_M = 0;
  logic [31:0] ALU_OUT_E, WRITE_DATA_E;
  logic [3:0] md_op = 0;
  logic md_busy, md_stall;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_hi = 0, m_lo = 0;

  execute_md_stage dut (
    .clk(clk), .reset_n(reset_n), .rs_sel(rs_sel), .rt_sel(rt_sel), .srcb_sel(srcb_sel),
    .alu_ctr(alu_ctr), .a3_sel(a3_sel), .rd_E(rd_E), .rt_E(rt_E), .RD1_E(RD1_E), .RD2_E(RD2_E),
    .E32_E(E32_E), .ALU_OUT_M(ALU_OUT_M), .RESULT_W(RESULT_W), .PC8_M(PC8_M), .md_op(md_op),
    .md_req_D(md_req_D), .WRITE_REG_E(WRITE_REG_E), .ALU_OUT_E(ALU_OUT_E),
    .WRITE_DATA_E(WRITE_DATA_E), .md_busy(md_busy), .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] rs, rt;
    logic sb;
    logic [2:0] alu;
    logic [1:0] a3;
    logic [4:0] rd, rtr;
    logic [31:0] rd1, rd2, e32, am, rw, pc8, ealu, ewd;
    logic [4:0] ewr;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd_ref(input logic [1:0] s, input logic [31:0] r, am, rw, pc8);
    case (s)
      2'd0: return r;
      2'd1: return am;
      2'd2: return rw;
      default: return pc8;
    endcase
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~(a | b);
      3'd6: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: return (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [4:0] a3_ref(input logic [1:0] s, input logic [4:0] rd, rt);
    case (s)
      2'd0: return rt;
      2'd1: return rd;
      2'd2: return 5'd31;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [63:0] md_ref(input logic [3:0] op, input logic [31:0] a, b, input logic [63:0] acc);
    longint sp;
    logic [63:0] up;
    int q, r;
    sp = longint'(int'(a)) * longint'(int'(b));
    up = {32'b0, a} * {32'b0, b};
    case (op)
      4'd1: return sp;
      4'd2: return up;
      4'd3, 4'd4: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (op == 4'd4) return {a % b, a / b};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        return {r, q};
      end
      4'd9: return acc + sp;
      4'd10: return acc + up;
      4'd11: return acc - sp;
      default: return acc;
    endcase
  endfunction

  task automatic read_hilo(input string nm);
    md_op = 4'd7;
    #1 chk({nm, "_hi"}, ALU_OUT_E, m_hi);
    md_op = 4'd8;
    #1 chk({nm, "_lo"}, ALU_OUT_E, m_lo);
    md_op = 4'd0;
  endtask

  task automatic run_md(input logic [3:0] op, input logic [31:0] a, b, input bit junk, input string nm);
    int lat, n;
    logic [63:0] e;
    lat = (op == 4'd3 || op == 4'd4) ? DL : ML;
    e = md_ref(op, a, b, {m_hi, m_lo});
    @(negedge clk);
    rs_sel = 0; rt_sel = 0; RD1_E = a; RD2_E = b; md_op = op; md_req_D = 1;
    #1 chk({nm, "_stall_start"}, 32'(md_stall), 1);
    chk({nm, "_idle_start"}, 32'(md_busy), 0);
    @(negedge clk);
    md_op = junk ? 4'd6 : 4'd0;
    RD1_E = $urandom;
    #1 n = 0;
    while (md_busy && n < 100) begin
      chk({nm, "_stall_busy"}, 32'(md_stall), 1);
      n++;
      @(negedge clk);
      md_op = (junk && md_busy) ? 4'd6 : 4'd0;
      #1;
    end
    chk({nm, "_busy_cycles"}, 32'(n), 32'(lat));
    chk({nm, "_stall_after"}, 32'(md_stall), 0);
    m_hi = e[63:32];
    m_lo = e[31:0];
    read_hilo(nm);
    md_req_D = 0;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v, input string nm);
    @(negedge clk);
    rs_sel = 0; RD1_E = v; md_op = op;
    @(negedge clk);
    md_op = 0;
    if (op == 4'd5) m_hi = v; else m_lo = v;
    read_hilo(nm);
  endtask

  initial begin
    vt[0] = '{2'd1, 2'd0, 1'b1, 3'd0, 2'd0, 5'd3, 5'd7, 32'h99, 32'h5, 32'h4, 32'h10, 32'h0, 32'h0, 32'h14, 32'h5, 5'd7};
    vt[1] = '{2'd2, 2'd1, 1'b0, 3'd1, 2'd1, 5'd9, 5'd2, 32'h0, 32'h0, 32'h0, 32'h3, 32'h10, 32'h0, 32'hD, 32'h3, 5'd9};
    vt[2] = '{2'd3, 2'd2, 1'b0, 3'd2, 2'd2, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0FF0, 32'hF0F0, 32'h00F0, 32'h0FF0, 5'd31};
    vt[3] = '{2'd0, 2'd3, 1'b0, 3'd6, 2'd3, 5'd4, 5'd5, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h1, 32'h1, 5'd0};
    vt[4] = '{2'd0, 2'd0, 1'b0, 3'd7, 2'd0, 5'd4, 5'd5, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 5'd5};
    vt[5] = '{2'd0, 2'd0, 1'b1, 3'd5, 2'd1, 5'd31, 5'd2, 32'h0000FFFF, 32'h1234, 32'h00FF0000, 32'h0, 32'h0, 32'h0, 32'hFF000000, 32'h1234, 5'd31};
    vt[6] = '{2'd0, 2'd0, 1'b1, 3'd3, 2'd0, 5'd1, 5'd0, 32'hA5A5A5A5, 32'h0, 32'hFFFF0000, 32'h0, 32'h0, 32'h0, 32'hFFFFA5A5, 32'h0, 5'd0};
    vt[7] = '{2'd0, 2'd1, 1'b1, 3'd0, 2'd1, 5'd12, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h2, 32'h77, 32'h0, 32'h0, 32'h1, 32'h77, 5'd12};
    #1;
    chk("rst_busy", 32'(md_busy), 0);
    md_op = 4'd7;
    #1 chk("rst_hi", ALU_OUT_E, 0);
    md_op = 4'd8;
    #1 chk("rst_lo", ALU_OUT_E, 0);
    md_op = 4'd0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    foreach (vt[i]) begin
      @(negedge clk);
      rs_sel = vt[i].rs; rt_sel = vt[i].rt; srcb_sel = vt[i].sb; alu_ctr = vt[i].alu;
      a3_sel = vt[i].a3; rd_E = vt[i].rd; rt_E = vt[i].rtr; RD1_E = vt[i].rd1; RD2_E = vt[i].rd2;
      E32_E = vt[i].e32; ALU_OUT_M = vt[i].am; RESULT_W = vt[i].rw; PC8_M = vt[i].pc8;
      #1 chk($sformatf("vec%0d_alu", i), ALU_OUT_E, vt[i].ealu);
      chk($sformatf("vec%0d_wd", i), WRITE_DATA_E, vt[i].ewd);
      chk($sformatf("vec%0d_wr", i), 32'(WRITE_REG_E), 32'(vt[i].ewr));
    end
    for (int i = 0; i < 100; i++) begin
      logic [31:0] a, b, rt;
      @(negedge clk);
      rs_sel = 2'($urandom); rt_sel = 2'($urandom); srcb_sel = 1'($urandom); alu_ctr = 3'($urandom);
      a3_sel = 2'($urandom); rd_E = 5'($urandom); rt_E = 5'($urandom); RD1_E = $urandom;
      RD2_E = $urandom; E32_E = $urandom; ALU_OUT_M = $urandom; RESULT_W = $urandom;
      PC8_M = $urandom; md_req_D = 1'($urandom);
      a = fwd_ref(rs_sel, RD1_E, ALU_OUT_M, RESULT_W, PC8_M);
      rt = fwd_ref(rt_sel, RD2_E, ALU_OUT_M, RESULT_W, PC8_M);
      b = srcb_sel ? E32_E : rt;
      #1 chk("rnd_alu", ALU_OUT_E, alu_ref(alu_ctr, a, b));
      chk("rnd_wd", WRITE_DATA_E, rt);
      chk("rnd_wr", 32'(WRITE_REG_E), 32'(a3_ref(a3_sel, rd_E, rt_E)));
      chk("rnd_stall", 32'(md_stall), 0);
    end
    md_req_D = 0;
    @(negedge clk);
    rs_sel = 0; rt_sel = 0; RD1_E = 5; RD2_E = 6; md_op = 4'd1;
    #1 chk("nostall_noreq", 32'(md_stall), 0);
    md_op = 4'd0;
    @(negedge clk);
    chk("no_start", 32'(md_busy), 0);
    run_md(4'd1, 32'hFFFFFFFE, 32'd3, 0, "mult");
    run_md(4'd4, 32'd7, 32'd0, 0, "divu0");
    run_md(4'd3, 32'hFFFFFFF9, 32'd2, 1, "div_neg");
    run_md(4'd3, 32'h80000000, 32'hFFFFFFFF, 0, "div_ovf");
    run_md(4'd3, 32'hFFFFFFF9, 32'd0, 0, "div0");
    run_md(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, "multu");
    mt(4'd5, 32'hCAFEF00D, "mthi");
    mt(4'd6, 32'h12345678, "mtlo");
    for (int i = 0; i < 16; i++) begin
      logic [3:0] op;
      logic [31:0] a, b;
      op = 4'($urandom_range(1, 4));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 1) == 0) b = $urandom_range(1, 300) * (($urandom_range(0, 1) == 1) ? -1 : 1);
      if ($urandom_range(0, 5) == 0) b = 0;
      if (op == 4'd3 && $urandom_range(0, 5) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      run_md(op, a, b, 1'($urandom), $sformatf("rnd_md%0d", i));
      if ($urandom_range(0, 2) == 0) mt(4'($urandom_range(5, 6)), $urandom, "rnd_mt");
    end
`ifdef MDU_ACCUM_EN
    mt(4'd5, 32'h0, "acc_hi0");
    mt(4'd6, 32'hFFFFFFFF, "acc_lo1");
    run_md(4'd10, 32'd1, 32'd1, 0, "maddu");
    for (int i = 0; i < 6; i++)
      run_md(4'($urandom_range(9, 11)), $urandom, $urandom, 1'($urandom), "rnd_acc");
`endif
    run_md(4'd1, 32'h12345, 32'h777, 0, "pre_rst");
    @(negedge clk);
    RD1_E = 3; RD2_E = 5; md_op = 4'd2;
    @(negedge clk);
    md_op = 0;
    @(negedge clk);
    #1 reset_n = 0;
    #1 chk("midrst_busy", 32'(md_busy), 0);
    m_hi = 0;
    m_lo = 0;
    read_hilo("midrst");
    reset_n = 1;
    repeat (12) @(negedge clk);
    chk("postrst_busy", 32'(md_busy), 0);
    read_hilo("postrst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/execute_md_stage.md
Name: execute_md_stage

Overview:
- Parametrised next-generation pipeline execute stage.
- Keeps the existing functions: RS/RT forwarding selection, SrcB immediate select, ALU, and destination-register select.
- Adds a multi-cycle multiply/divide unit (MDU) with HI/LO registers, a busy counter and a decode-stage stall output.
- Sits between the D/E and E/M pipeline registers; ALU_OUT_E and WRITE_DATA_E feed the E/M register.

Parameters:
- DATA_W, 32, datapath width; HI/LO are DATA_W each.
- REG_W, 5, register-index width.
- MULT_LAT, 5, cycles the MDU stays busy for mult/multu (>=1).
- DIV_LAT, 10, cycles the MDU stays busy for div/divu (>=1).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- rs_sel  in  2  SrcA forward select: 0 RD1_E, 1 ALU_OUT_M, 2 RESULT_W, 3 PC8_M.
- rt_sel  in  2  RT forward select, same encoding; the result drives WRITE_DATA_E.
- srcb_sel  in  1  0 forwarded RT, 1 E32_E.
- alu_ctr  in  3  existing ALU operation code.
- a3_sel  in  2  0 rt_E, 1 rd_E, 2 constant 31, 3 zero.
- rd_E, rt_E  in  REG_W  register indices.
- RD1_E, RD2_E, E32_E  in  DATA_W  register file and extended-immediate values.
- ALU_OUT_M, RESULT_W, PC8_M  in  DATA_W  forwarding sources.
- md_op  in  4  MDU operation of the E-stage instruction.
- md_req_D  in  1  the D-stage instruction uses the MDU.
- WRITE_REG_E  out  REG_W  destination register.
- ALU_OUT_E  out  DATA_W  ALU result, or HI/LO for mfhi/mflo.
- WRITE_DATA_E  out  DATA_W  forwarded RT value.
- md_busy  out  1  MDU operation in flight.
- md_stall  out  1  stall request for the D stage.

Behaviour:
- Forwarding muxes, SrcB mux, ALU and A3 mux are purely combinational, same cycle.
- md_op encoding:
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO.
  - 9-11 are reserved for the optional feature.
  - Any other value is treated as NONE.
- Start condition: md_op is MULT/MULTU/DIV/DIVU and md_busy=0.
  - At that edge the full result is computed from SrcA/forwarded RT and stored in pend_hi/pend_lo.
  - cnt loads MULT_LAT or DIV_LAT; md_busy=1 from the next cycle.
- While busy: cnt decrements each edge.
  - At the edge where cnt goes 1->0, HI<=pend_hi, LO<=pend_lo and md_busy falls.
  - md_busy is high for exactly LAT cycles.
- Result layout:
  - mult/multu: {HI,LO} = 2*DATA_W-bit signed/unsigned product.
  - div/divu: LO = quotient truncated toward zero, HI = remainder carrying the dividend's sign.
- Divide by zero: no trap; LO = all ones, HI = dividend.
- Signed overflow (most-negative / -1): LO = most-negative value, HI = 0.
- MTHI/MTLO: HI or LO <= SrcA at the edge, when not busy.
- MFHI/MFLO: ALU_OUT_E = HI/LO combinationally.
  - HI/LO values committed at the same edge are visible in the next cycle, not the same cycle.
- Any md_op while md_busy=1 is ignored; upstream must not issue one, and the stall guarantees this.
- md_stall = md_req_D & (md_busy | start condition this cycle).
- Reset (asynchronous, mid-operation included): HI=0, LO=0, cnt=0, md_busy=0, pend_*=0.
  - Any in-flight operation is discarded.
  - Combinational outputs follow their inputs.

Optional Feature:
- Macro: MDU_ACCUM_EN.
- Defined:
  - Adds op 9 MADD, 10 MADDU, 11 MSUB; each takes MULT_LAT cycles.
  - {HI,LO} <= {HI,LO} ± product, mod 2^(2*DATA_W).
  - The accumulator base is HI/LO as sampled at the start edge.
- Undefined: ops 9-11 decode as NONE; there is no accumulate logic.

Decomposition:
- Shared package `md_pkg`:
  - md_op codes.
  - Forward-select and A3-select encodings.
  - Constant LINK_REG=31.
- Sub-module `mdu_core`:
  - Holds cnt, pend, HI/LO and busy logic.
  - Ports: clk, reset_n, op, a, b, busy, hi, lo.
- The existing ALU module is instantiated unchanged.

Test Plan:
- rs_sel=1, ALU_OUT_M=0x10, RD1_E=0x99, alu_ctr=add, srcb_sel=1, E32_E=4 -> ALU_OUT_E=0x14 in the same cycle.
- MULT, A=0xFFFFFFFE (-2), B=3 -> md_busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; next-cycle MFLO -> 0xFFFFFFFA.
- DIVU 7/0 -> after 10 busy cycles, LO=0xFFFFFFFF, HI=7. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- md_req_D=1 in the start cycle and in all busy cycles -> md_stall=1; md_stall=0 in the cycle after md_busy falls.
- MULT started, reset_n pulsed low at busy cycle 2 -> md_busy=0, HI=LO=0 immediately; the result is never committed.
- With MDU_ACCUM_EN: HI=0, LO=0xFFFFFFFF, MADDU 1*1 -> HI=1, LO=0.
